// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: shifts a fixed PATTERN out MSB first, repeat_n times
// back-to-back, with ready/valid/done handshakes for driving serial detectors.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | ready=1, waiting for start with a non-zero repeat_n
//   SEND   | valid=1, x = MSB of shreg, one pattern bit per clock
//   DONE   | one-cycle done pulse, ready returns on the following edge
module seq_pattern_tx #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1010,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             ready,
    output logic             x,
    output logic             valid,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_REP  = CNT_W'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic [CNT_W-1:0] repcnt;

    // shreg is cleared whenever nothing is being sent, so its MSB flop doubles as x
    assign x = shreg[WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            repcnt <= '0;
            ready  <= 1'b1;
            valid  <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (repeat_n != '0)) begin
                        state  <= S_SEND;
                        shreg  <= PATTERN;
                        bitcnt <= '0;
                        repcnt <= repeat_n;
                        ready  <= 1'b0;
                        valid  <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (bitcnt == LAST_BIT) begin
                        if (repcnt > ONE_REP) begin
                            // next repetition starts on the very next cycle, no gap
                            shreg  <= PATTERN;
                            bitcnt <= '0;
                            repcnt <= repcnt - ONE_REP;
                        end else begin
                            state  <= S_DONE;
                            shreg  <= '0;
                            bitcnt <= '0;
                            valid  <= 1'b0;
                            done   <= 1'b1;
                        end
                    end else begin
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                        bitcnt <= bitcnt + BW'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end

                default: begin
                    state  <= S_IDLE;
                    shreg  <= '0;
                    bitcnt <= '0;
                    repcnt <= '0;
                    ready  <= 1'b1;
                    valid  <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes expected bits/done pulses,
// a negedge monitor pops and compares whenever valid or done is presented.
module tb_seq_pattern_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] repeat_n;
    logic       ready;
    logic       x;
    logic       valid;
    logic       done;

    seq_pattern_tx #(.WIDTH(4), .PATTERN(4'b1010), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .repeat_n (repeat_n),
        .ready    (ready),
        .x        (x),
        .valid    (valid),
        .done     (done)
    );

    typedef struct packed {
        logic is_done;
        logic b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic [3:0]  pat = 4'b1010;
    logic [31:0] last_zmask = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_pattern(input int reps, input bit with_done);
        exp_t e;
        for (int r = 0; r < reps; r++) begin
            for (int i = 3; i >= 0; i--) begin
                e.is_done = 1'b0;
                e.b       = pat[i];
                exp_q.push_back(e);
            end
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.b       = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // drives a one-cycle start; returns #1 after the accepting edge
    task automatic issue(input int reps);
        push_pattern(reps, 1'b1);
        start    = 1'b1;
        repeat_n = 4'(reps);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_ready_timeout"}, 32'(seen), 32'd1);
        @(posedge clk); #2;
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // monitor: scoreboard compare plus a 1010 overlap detector over each contiguous stream
    initial begin
        exp_t       e;
        logic [3:0] hist = '0;
        int         bitpos = 0;
        logic [31:0] zmask = '0;
        logic       prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (valid && done) begin
                total++;
                bad++;
                $display("FAIL valid_and_done: both high at %0t", $time);
            end
            if (valid || done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: valid=%0b done=%0b x=%0b with empty queue at %0t",
                             valid, done, x, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_kind", 32'(done), 32'(e.is_done));
                    if (!e.is_done) check("out_bit", 32'(x), 32'(e.b));
                end
            end
            if (valid) begin
                if (!prev_valid) begin
                    hist   = '0;
                    bitpos = 0;
                    zmask  = '0;
                end
                hist = {hist[2:0], x};
                bitpos++;
                if (bitpos >= 4 && hist == 4'b1010) zmask[bitpos-1] = 1'b1;
            end
            if (done) last_zmask = zmask;
            prev_valid = valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        repeat_n = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_x",     32'(x),     32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_done",  32'(done),  32'd0);

        // reset wins over a simultaneous start
        start = 1'b1; repeat_n = 4'd1;
        @(posedge clk); #1;
        check("rst_prio_ready", 32'(ready), 32'd1);
        check("rst_prio_valid", 32'(valid), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        // single repetition with exact cycle timing
        issue(1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check($sformatf("t1_valid_c%0d", i), 32'(valid), 32'(i <= 4));
            check($sformatf("t1_ready_c%0d", i), 32'(ready), 32'(i == 6));
        end
        @(posedge clk); #2;
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // three back-to-back repetitions, no valid gap, detector hits at 4,6,8,10,12
        issue(3);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("t2_valid_c%0d", i), 32'(valid), 32'd1);
        end
        wait_idle("t2");
        check("t2_z_positions", last_zmask, 32'h0000_0AA8);

        // repeat_n=0 is ignored
        start = 1'b1; repeat_n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_idle", {29'd0, ready, valid, done}, 32'b100);
        end
        start = 1'b0;
        @(posedge clk); #1;

        // start pulse during bit 3 and repeat_n change are ignored
        issue(2);
        @(posedge clk); @(posedge clk); #1;
        start = 1'b1; repeat_n = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("t4");
        repeat (3) @(posedge clk);
        #2;
        check("t4_no_extra", 32'(exp_q.size()), 32'd0);

        // reset while bit 6 is on the line abandons the stream without done
        push_pattern(1, 1'b0);
        push_pattern(1, 1'b0);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        start = 1'b1; repeat_n = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_after_rst", {28'd0, valid, x, ready, done}, 32'b0010);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        issue(1);
        wait_idle("t5_restart");

        // start held high: period of 6 cycles per pattern
        push_pattern(1, 1'b1);
        push_pattern(1, 1'b1);
        start = 1'b1; repeat_n = 4'd1;
        @(posedge clk); #1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check($sformatf("t6_valid_c%0d", i), 32'(valid),
                  32'((i >= 1 && i <= 4) || (i >= 7 && i <= 10)));
            check($sformatf("t6_done_c%0d", i), 32'(done), 32'(i == 5 || i == 11));
            if (i == 11) start = 1'b0;
        end
        wait_idle("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
